rcu_cfg: RTL and testbench

RCU_CFG -- requirements
Module: rcu_cfg

---
 rtl/rcu_cfg.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rcu_cfg.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcu_cfg.sv
// ---------------------------------------------------------------------------
// rcu_cfg -- receiver control unit for a configurable asynchronous serial RX.
//
// Sequences one frame: start bit, 5..MAX_DATA_BITS data bits, an optional
// parity bit and one or two stop bits. The bit timer, the receive shift
// register, the stop-bit checker and the RX buffer are external. This block
// tells them when to run, shift, clear and load, and it keeps the status
// flags.
//
// The frame format (length, parity enable/sense, stop count) is captured
// when the start edge is accepted. Changing those inputs during a frame has
// no effect until the next frame.
//
// Ports
//   clk                  system clock, rising-edge active
//   n_rst                asynchronous active-low reset
//   new_packet_detected  start-edge pulse from the edge detector
//   bit_strobe           one-cycle pulse at each bit centre
//   bit_val              sampled line value, valid with bit_strobe
//   data_bits            data-field length (clamped to 5..MAX_DATA_BITS)
//   parity_en            parity bit present
//   parity_odd           1 = odd parity, 0 = even parity
//   two_stop             1 = two stop bits, 0 = one stop bit
//   data_read            consumer acknowledge of the buffered byte
//   sbc_clear            one-cycle clear of the stop-bit checker / staging
//   enable_timer         run the bit timer (START, DATA, PARITY, STOP)
//   shift_enable         shift bit_val into the shift register (DATA only)
//   load_buffer          one-cycle copy of the shift register to the buffer
//   data_ready           RX buffer holds unread data
//   framing_error        last completed frame had a low stop bit
//   parity_error         last completed frame had a parity mismatch
//   overrun_error        unread data was overwritten by a new frame
// ---------------------------------------------------------------------------
module rcu_cfg #(
    parameter int MAX_DATA_BITS = 8,
    parameter int CNT_W         = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             new_packet_detected,
    input  logic             bit_strobe,
    input  logic             bit_val,
    input  logic [CNT_W-1:0] data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop,
    input  logic             data_read,
    output logic             sbc_clear,
    output logic             enable_timer,
    output logic             shift_enable,
    output logic             load_buffer,
    output logic             data_ready,
    output logic             framing_error,
    output logic             parity_error,
    output logic             overrun_error
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK,
        LOAD
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(5);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_DATA_BITS);

    state_t           state;
    state_t           next_state;

    // Frame format captured at the start edge.
    logic [CNT_W-1:0] len_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic             two_stop_q;

    // Per-frame working state.
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [CNT_W-1:0] len_clamped;
    logic             par_acc;     // running XOR of the data bits
    logic             stage_fe;    // framing error seen on any stop bit
    logic             stage_pe;    // parity mismatch seen on the parity bit
    logic             stop_seen;   // first of two stop bits already sampled

    // Out-of-range lengths are folded into the supported range at capture
    // time, so the DATA exit compare never has to handle them.
    always_comb begin
        len_clamped = data_bits;
        if (data_bits < MIN_LEN) begin
            len_clamped = MIN_LEN;
        end else if (data_bits > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end
    end

    assign bit_cnt_inc = bit_cnt + CNT_W'(1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation and a mismatch against synthesis.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so that every path
    // assigns it; a missing branch would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (new_packet_detected) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                next_state = START;
            end
            START: begin
                // A high start sample is a glitch, not a frame: drop it.
                if (bit_strobe) begin
                    next_state = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_strobe && (bit_cnt_inc == len_q)) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    next_state = (two_stop_q && !stop_seen) ? STOP : CHECK;
                end
            end
            CHECK: begin
                next_state = (stage_fe || stage_pe) ? IDLE : LOAD;
            end
            LOAD: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore outputs (shift_enable is the only Mealy term)
    // -----------------------------------------------------------------------
    assign sbc_clear    = (state == CLEAR);
    assign load_buffer  = (state == LOAD);
    assign enable_timer = (state == START) || (state == DATA) ||
                          (state == PARITY) || (state == STOP);
    assign shift_enable = (state == DATA) && bit_strobe;

    // -----------------------------------------------------------------------
    // Config capture, bit counter, parity accumulator, error staging and
    // the framing/parity status flags.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len_q         <= '0;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            two_stop_q    <= 1'b0;
            bit_cnt       <= '0;
            par_acc       <= 1'b0;
            stage_fe      <= 1'b0;
            stage_pe      <= 1'b0;
            stop_seen     <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (new_packet_detected) begin
                        len_q      <= len_clamped;
                        par_en_q   <= parity_en;
                        par_odd_q  <= parity_odd;
                        two_stop_q <= two_stop;
                    end
                end
                CLEAR: begin
                    bit_cnt   <= '0;
                    par_acc   <= 1'b0;
                    stage_fe  <= 1'b0;
                    stage_pe  <= 1'b0;
                    stop_seen <= 1'b0;
                end
                DATA: begin
                    if (bit_strobe) begin
                        par_acc <= par_acc ^ bit_val;
                        bit_cnt <= bit_cnt_inc;
                    end
                end
                PARITY: begin
                    // XOR over data plus parity is 1 for an odd count of ones.
                    if (bit_strobe) begin
                        stage_pe <= ((par_acc ^ bit_val) != par_odd_q);
                    end
                end
                STOP: begin
                    // Sticky, so a bad first stop bit survives a good second.
                    if (bit_strobe) begin
                        if (!bit_val) begin
                            stage_fe <= 1'b1;
                        end
                        stop_seen <= 1'b1;
                    end
                end
                CHECK: begin
                    framing_error <= stage_fe;
                    parity_error  <= stage_pe;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RX buffer status. A load coinciding with the consumer's acknowledge
    // replaces the byte just read, so it is neither an overrun nor a reason
    // to drop data_ready.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end else if (state == LOAD) begin
            data_ready <= 1'b1;
            if (data_read) begin
                overrun_error <= 1'b0;
            end else if (data_ready) begin
                overrun_error <= 1'b1;
            end
        end else if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rcu_cfg.sv
// ---------------------------------------------------------------------------
// tb_rcu_cfg -- directed bench for rcu_cfg.
//
// A frame-level model predicts the status flags, the number of shift, load
// and clear pulses and the bits shifted in, from the frame contents alone.
// Between frames a compare process checks every cycle that the flags match
// the model and that the control outputs are quiet.
// ---------------------------------------------------------------------------
module tb_rcu_cfg;

    localparam int MAXB = 8;
    localparam int CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic          new_packet_detected;
    logic          bit_strobe;
    logic          bit_val;
    logic [CW-1:0] data_bits;
    logic          parity_en;
    logic          parity_odd;
    logic          two_stop;
    logic          data_read;
    logic          sbc_clear;
    logic          enable_timer;
    logic          shift_enable;
    logic          load_buffer;
    logic          data_ready;
    logic          framing_error;
    logic          parity_error;
    logic          overrun_error;

    rcu_cfg #(
        .MAX_DATA_BITS(MAXB),
        .CNT_W        (CW)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .new_packet_detected(new_packet_detected),
        .bit_strobe         (bit_strobe),
        .bit_val            (bit_val),
        .data_bits          (data_bits),
        .parity_en          (parity_en),
        .parity_odd         (parity_odd),
        .two_stop           (two_stop),
        .data_read          (data_read),
        .sbc_clear          (sbc_clear),
        .enable_timer       (enable_timer),
        .shift_enable       (shift_enable),
        .load_buffer        (load_buffer),
        .data_ready         (data_ready),
        .framing_error      (framing_error),
        .parity_error       (parity_error),
        .overrun_error      (overrun_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model of the status flags.
    bit m_dr  = 1'b0;
    bit m_fe  = 1'b0;
    bit m_pe  = 1'b0;
    bit m_ovr = 1'b0;
    bit settled = 1'b0;

    function automatic int exp_len(input int db);
        if (db < 5) return 5;
        if (db > MAXB) return MAXB;
        return db;
    endfunction

    // Pulse counters and captured shift data for the current frame.
    int          shift_cnt = 0;
    int          load_cnt  = 0;
    int          clr_cnt   = 0;
    logic [15:0] cap       = '0;

    always @(negedge clk) begin
        if (shift_enable) begin
            if (shift_cnt < 16) cap[shift_cnt] = bit_val;
            shift_cnt++;
        end
        if (load_buffer) load_cnt++;
        if (sbc_clear) clr_cnt++;
    end

    // Between frames: flags must match the model, controls must be quiet.
    always @(negedge clk) begin
        if (settled && n_rst) begin
            check("idle_data_ready", int'(data_ready), int'(m_dr));
            check("idle_framing_error", int'(framing_error), int'(m_fe));
            check("idle_parity_error", int'(parity_error), int'(m_pe));
            check("idle_overrun_error", int'(overrun_error), int'(m_ovr));
            check("idle_enable_timer", int'(enable_timer), 0);
            check("idle_shift_enable", int'(shift_enable), 0);
            check("idle_load_buffer", int'(load_buffer), 0);
            check("idle_sbc_clear", int'(sbc_clear), 0);
        end
    end

    // One bit period: strobe cycle followed by one quiet cycle.
    task automatic strobe(input logic v);
        bit_strobe = 1'b1;
        bit_val    = v;
        @(negedge clk);
        check("enable_timer_on_strobe", int'(enable_timer), 1);
        @(posedge clk);
        #1;
        bit_strobe = 1'b0;
        bit_val    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic packet(input string tag, input int data, input int db,
                          input bit pen, input bit podd, input bit ts,
                          input bit start_v, input bit par_v,
                          input bit stop1, input bit stop2,
                          input bit read_at_load);
        int len;
        int ones;
        int mask;
        bit fe;
        bit pe;
        settled   = 1'b0;
        shift_cnt = 0;
        load_cnt  = 0;
        clr_cnt   = 0;
        cap       = '0;
        len       = exp_len(db);
        mask      = (1 << len) - 1;
        data_bits  = CW'(db);
        parity_en  = pen;
        parity_odd = podd;
        two_stop   = ts;
        new_packet_detected = 1'b1;
        @(posedge clk);
        #1;
        new_packet_detected = 1'b0;
        // Scramble the format inputs: the captured copy must be used.
        data_bits  = ~data_bits;
        parity_en  = ~pen;
        parity_odd = ~podd;
        two_stop   = ~ts;
        @(posedge clk);
        #1;
        strobe(start_v);
        if (!start_v) begin
            for (int i = 0; i < len; i++) begin
                if (i == 1) new_packet_detected = 1'b1;
                strobe(data[i]);
                new_packet_detected = 1'b0;
            end
            if (pen) strobe(par_v);
            strobe(stop1);
            if (ts) strobe(stop2);
            if (read_at_load) begin
                data_read = 1'b1;
                @(posedge clk);
                #1;
                data_read = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        fe = 1'b0;
        pe = 1'b0;
        if (!start_v) begin
            ones = $countones(data & mask);
            fe   = !stop1 || (ts && !stop2);
            pe   = pen && (((ones + int'(par_v)) % 2) != int'(podd));
            m_fe = fe;
            m_pe = pe;
            if (!fe && !pe) begin
                if (read_at_load) begin
                    m_ovr = 1'b0;
                end else begin
                    m_ovr = m_ovr | m_dr;
                end
                m_dr = 1'b1;
            end
        end
        check({tag, "_shift_count"}, shift_cnt, start_v ? 0 : len);
        check({tag, "_load_count"}, load_cnt, (start_v || fe || pe) ? 0 : 1);
        check({tag, "_clear_count"}, clr_cnt, 1);
        if (!start_v) check({tag, "_shifted_bits"}, int'(cap), data & mask);
        settled = 1'b1;
    endtask

    task automatic read_data();
        settled   = 1'b0;
        data_read = 1'b1;
        @(posedge clk);
        #1;
        data_read = 1'b0;
        m_dr  = 1'b0;
        m_ovr = 1'b0;
        settled = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sbc_clear"}, int'(sbc_clear), 0);
        check({tag, "_enable_timer"}, int'(enable_timer), 0);
        check({tag, "_shift_enable"}, int'(shift_enable), 0);
        check({tag, "_load_buffer"}, int'(load_buffer), 0);
        check({tag, "_data_ready"}, int'(data_ready), 0);
        check({tag, "_framing_error"}, int'(framing_error), 0);
        check({tag, "_parity_error"}, int'(parity_error), 0);
        check({tag, "_overrun_error"}, int'(overrun_error), 0);
    endtask

    initial begin
        n_rst = 1'b1;
        new_packet_detected = 1'b0;
        bit_strobe = 1'b0;
        bit_val    = 1'b1;
        data_bits  = CW'(8);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        data_read  = 1'b0;
        #2 n_rst = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        #1 n_rst = 1'b1;
        settled = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1, 0xA5: clean load.
        packet("a5_8n1", 'hA5, 8, 0, 0, 0, 0, 0, 1, 1, 0);
        check("a5_lit_shifts", shift_cnt, 8);
        check("a5_lit_bits", int'(cap), 'hA5);
        check("a5_lit_data_ready", int'(data_ready), 1);
        read_data();

        // 7O1, 0x35 (four ones): parity bit 0 is wrong, 1 is right.
        packet("p35_bad", 'h35, 7, 1, 1, 0, 0, 0, 1, 1, 0);
        check("p35_lit_parity_error", int'(parity_error), 1);
        check("p35_lit_no_load", load_cnt, 0);
        packet("p35_good", 'h35, 7, 1, 1, 0, 0, 1, 1, 1, 0);
        check("p35_lit_parity_clear", int'(parity_error), 0);
        read_data();

        // 8N2: bad second stop, bad first stop, then clean.
        packet("stop2_bad", 'h3C, 8, 0, 0, 1, 0, 0, 1, 0, 0);
        check("stop2_lit_framing", int'(framing_error), 1);
        packet("stop1_bad", 'hC3, 8, 0, 0, 1, 0, 0, 0, 1, 0);
        packet("stop_ok", 'h81, 8, 0, 0, 1, 0, 0, 1, 1, 0);

        // False start, then a second frame with unread data -> overrun.
        packet("false_start", 'h00, 8, 0, 0, 0, 1, 0, 1, 1, 0);
        packet("overrun", 'h5A, 8, 0, 0, 0, 0, 0, 1, 1, 0);
        check("overrun_lit", int'(overrun_error), 1);

        // Load coinciding with data_read: stays ready, overrun cleared.
        packet("load_read", 'h0F, 8, 0, 0, 0, 0, 0, 1, 1, 1);
        check("load_read_lit_ready", int'(data_ready), 1);
        check("load_read_lit_overrun", int'(overrun_error), 0);
        read_data();

        // Length clamping: 3 -> 5 (even parity), 15 -> MAXB.
        packet("len3", 'h15, 3, 1, 0, 0, 0, 1, 1, 1, 0);
        check("len3_lit_shifts", shift_cnt, 5);
        packet("len15", 'hC3, 15, 0, 0, 0, 0, 0, 1, 1, 0);
        check("len15_lit_shifts", shift_cnt, 8);

        // Strobes in IDLE must be ignored.
        bit_strobe = 1'b1;
        bit_val    = 1'b0;
        @(posedge clk);
        #1 bit_strobe = 1'b0;
        bit_val = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of the data field.
        settled   = 1'b0;
        data_bits = CW'(8);
        parity_en = 1'b0;
        two_stop  = 1'b0;
        new_packet_detected = 1'b1;
        @(posedge clk);
        #1 new_packet_detected = 1'b0;
        @(posedge clk);
        #1;
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        bit_strobe = 1'b1;
        bit_val    = 1'b1;
        #2 n_rst = 1'b0;
        #1 check_all_zero("mid_reset");
        bit_strobe = 1'b0;
        m_dr  = 1'b0;
        m_fe  = 1'b0;
        m_pe  = 1'b0;
        m_ovr = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        settled = 1'b1;
        @(posedge clk);
        #1;
        packet("after_reset", 'h96, 8, 0, 0, 0, 0, 0, 1, 1, 0);
        check("after_reset_lit_load", load_cnt, 1);
        check("after_reset_lit_ready", int'(data_ready), 1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
